adder_result_accumulator: RTL and testbench
===========================================

Name: adder_result_accumulator

Overview:
- Downstream consumer of the four-bit adder: captures each {carry,sum} result and accumulates a batch of COUNT results into a wider register.
- Presents the batch total on a valid/ready output port.
- Provides the registered, handshaken stage between the combinational adder and downstream logic.

Parameters:
- ACC_W, 8, accumulator/output width in bits; legal range 5..16.
- COUNT, 4, number of adder results per batch; legal range 1..7.
- CNT_W, 3, width of the result counter; COUNT must be at most 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  adder result present on sum/carry.
- in_ready  output  1  block can accept a result this cycle.
- sum  input  4  adder sum bits.
- carry  input  1  adder carry-out.
- out_valid  output  1  batch total valid.
- out_ready  input  1  downstream accepts the total.
- acc_out  output  ACC_W  registered running/batch total.
- ovf  output  1  sticky: batch total wrapped modulo 2^ACC_W.
- cnt  output  CNT_W  results accepted in current batch.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high, asserting immediately and releasing synchronously to clk.
- Reset values: state=IDLE, acc_out=0, ovf=0, cnt=0, out_valid=0, in_ready=1.
- Operand: value = {carry,sum}, 5 bits unsigned, range 0..31, zero-extended to ACC_W+1 bits for the add.
- Accept: occurs on a rising edge with in_valid && in_ready.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On accept: acc_out<=value, cnt<=1, ovf<=0.
    - Go to DONE if COUNT==1, else ACCUM.
    - No accept: hold.
  - ACCUM: in_ready=1, out_valid=0.
    - On accept: acc_out<=(acc_out+value) mod 2^ACC_W, cnt<=cnt+1.
    - ovf<=ovf | carry-out of the ACC_W-bit add.
    - When cnt+1==COUNT, go to DONE.
    - No accept: hold all registers.
  - DONE: in_ready=0, out_valid=1; acc_out, ovf and cnt are stable.
    - On out_valid && out_ready: go to IDLE with acc_out<=0, cnt<=0, ovf<=0.
    - ovf stays readable while out_valid is high.
- Latency:
  - acc_out reflects an accepted result on the edge it is accepted.
  - out_valid rises on the same edge that accepts the COUNT-th result.
  - The earliest new-batch accept is the cycle after the out handshake (one-cycle bubble, by design).
- Data gating: in_valid while in DONE is ignored; sum and carry are not sampled.
- Output hold: out_valid must not drop and acc_out must not change until out_ready is seen.
- in_ready is a function of state only; it is not combinational on in_valid or out_ready.
- Reset mid-batch: async return to reset values on assertion; the partial batch is discarded.
- Wrap-around: with ACC_W=5 (minimum), a single 31 followed by 1 gives acc_out=0 and ovf=1.
- ovf clearing: ovf is cleared only by reset or by the first accept of a new batch; it is never cleared mid-batch.

Test Plan:
- Default parameters; feed 4 results with 1-cycle gaps: (sum=4'b1101,c=0), (4'b1001,0), (4'b0110,0), (4'b1101,0).
  - Required: cnt steps 1,2,3,4; acc_out=13,22,28,41 (8'h29); out_valid=1 on the 4th accept edge; ovf=0.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with sum=4'hF,c=1.
  - Required: acc_out stays 41; in_ready=0 every cycle; the result is not absorbed.
  - Then pulse out_ready: next cycle state IDLE, acc_out=0, in_ready=1.
- ACC_W=6: feed 4× (sum=4'hF,c=1).
  - Required: acc_out=31,62,29,60; ovf set at 3rd accept and still 1 at out_valid.
- Assert rst asynchronously between clock edges after 2 accepts of 5 and 5.
  - Required: acc_out=0, cnt=0, out_valid=0 immediately, without waiting for a clock edge.
  - A following 4-result batch totals correctly from 0.
- in_valid toggling 1,0,1,0,... with value 1 each accept, out_ready held at 1.
  - Required: batches complete every 4 accepts with acc_out=4.
  - out_valid high exactly one cycle per batch; one idle cycle before the next accept.
- COUNT=1: a single accept of (sum=4'h3,c=1).
  - Required: out_valid=1 with acc_out=19 on that edge; cnt=1.

Source files
------------

// File: rtl/adder_result_accumulator_if.sv
// Valid/ready bundle between the 4-bit adder, the result accumulator and its consumer.
interface adder_result_accumulator_if #(
    parameter int ACC_W = 8,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sum;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    modport master (
        output in_valid, sum, carry, out_ready,
        input  in_ready, out_valid, acc_out, ovf, cnt
    );

    modport slave (
        input  in_valid, sum, carry, out_ready,
        output in_ready, out_valid, acc_out, ovf, cnt
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates COUNT {carry,sum} adder results into an ACC_W-bit total and
// offers the batch total downstream on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for the first result of a batch
// ACCUM | batch partially collected, adding further results
// DONE  | batch total held on acc_out until out_ready
module adder_result_accumulator #(
    parameter int ACC_W = 8,
    parameter int COUNT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    adder_result_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             ovf_r, ovf_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;

    logic [ACC_W:0]   value;
    logic [ACC_W:0]   sum_wide;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    // Extra top bit of the add carries the wrap indication into ovf.
    assign value    = {{(ACC_W-4){1'b0}}, bus.carry, bus.sum};
    assign sum_wide = {1'b0, acc} + value;
    assign cnt_inc  = cnt_r + CNT_W'(1);
    assign accept   = bus.in_valid && (state != DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf_r <= ovf_nxt;
            cnt_r <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf_r;
        cnt_nxt   = cnt_r;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = value[ACC_W-1:0];
                    cnt_nxt   = CNT_W'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = (COUNT == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = sum_wide[ACC_W-1:0];
                    ovf_nxt = ovf_r | sum_wide[ACC_W];
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_W'(COUNT)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs depend on state alone, never on in_valid/out_ready.
    assign bus.in_ready  = (state != DONE);
    assign bus.out_valid = (state == DONE);
    assign bus.acc_out   = acc;
    assign bus.ovf       = ovf_r;
    assign bus.cnt       = cnt_r;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Self-checking bench: four accumulator configurations, directed and randomized batches.
module tb_adder_result_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    adder_result_accumulator_if #(.ACC_W(8), .CNT_W(3)) i0 ();
    adder_result_accumulator_if #(.ACC_W(6), .CNT_W(3)) i6 ();
    adder_result_accumulator_if #(.ACC_W(8), .CNT_W(3)) i1 ();
    adder_result_accumulator_if #(.ACC_W(5), .CNT_W(3)) i5 ();

    adder_result_accumulator #(.ACC_W(8), .COUNT(4), .CNT_W(3)) u0 (.clk(clk), .rst(rst), .bus(i0));
    adder_result_accumulator #(.ACC_W(6), .COUNT(4), .CNT_W(3)) u6 (.clk(clk), .rst(rst), .bus(i6));
    adder_result_accumulator #(.ACC_W(8), .COUNT(1), .CNT_W(3)) u1 (.clk(clk), .rst(rst), .bus(i1));
    adder_result_accumulator #(.ACC_W(5), .COUNT(2), .CNT_W(3)) u5 (.clk(clk), .rst(rst), .bus(i5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input bit iv, input logic [3:0] s, input bit cy, input bit orr);
        case (sel)
            0: begin i0.in_valid = iv; i0.sum = s; i0.carry = cy; i0.out_ready = orr; end
            1: begin i6.in_valid = iv; i6.sum = s; i6.carry = cy; i6.out_ready = orr; end
            2: begin i1.in_valid = iv; i1.sum = s; i1.carry = cy; i1.out_ready = orr; end
            default: begin i5.in_valid = iv; i5.sum = s; i5.carry = cy; i5.out_ready = orr; end
        endcase
    endtask

    task automatic sample(input int sel, output int acc, output int c, output bit ov,
                          output bit ir, output bit ovl);
        case (sel)
            0: begin acc = int'(i0.acc_out); c = int'(i0.cnt); ov = i0.ovf; ir = i0.in_ready; ovl = i0.out_valid; end
            1: begin acc = int'(i6.acc_out); c = int'(i6.cnt); ov = i6.ovf; ir = i6.in_ready; ovl = i6.out_valid; end
            2: begin acc = int'(i1.acc_out); c = int'(i1.cnt); ov = i1.ovf; ir = i1.in_ready; ovl = i1.out_valid; end
            default: begin acc = int'(i5.acc_out); c = int'(i5.cnt); ov = i5.ovf; ir = i5.in_ready; ovl = i5.out_valid; end
        endcase
    endtask

    task automatic test_reset();
        int acc, c; bit ov, ir, ovl;
        for (int s = 0; s < 4; s++) drive(s, 0, 4'h0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            sample(s, acc, c, ov, ir, ovl);
            n_cmp++;
            if (acc !== 0 || c !== 0 || ov !== 1'b0 || ir !== 1'b1 || ovl !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got acc=%0d cnt=%0d ovf=%0b in_ready=%0b out_valid=%0b, want 0 0 0 1 0",
                         s, acc, c, ov, ir, ovl);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed_batch();
        int sums [4] = '{13, 9, 6, 13};
        int total = 0;
        int acc, c; bit ov, ir, ovl;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 4'(sums[i]), 0, 0);
            tick();
            total += sums[i];
            sample(0, acc, c, ov, ir, ovl);
            n_cmp++;
            if (acc !== total || c !== i + 1 || ovl !== (i == 3) || ov !== 1'b0) begin
                n_bad++;
                $display("FAIL batch[%0d]: got acc=%0d cnt=%0d out_valid=%0b ovf=%0b, want %0d %0d %0b 0",
                         i, acc, c, ovl, ov, total, i + 1, (i == 3));
            end
            drive(0, 0, 4'h0, 0, 0);
            if (i < 3) tick();
        end
    endtask

    task automatic test_done_hold();
        int acc, c; bit ov, ir, ovl;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 4'hF, 1, 0);
            sample(0, acc, c, ov, ir, ovl);
            n_cmp++;
            if (ir !== 1'b0 || ovl !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_ready[%0d]: got in_ready=%0b out_valid=%0b, want 0 1", i, ir, ovl);
            end
            tick();
            sample(0, acc, c, ov, ir, ovl);
            n_cmp++;
            if (acc !== 41 || c !== 4 || ovl !== 1'b1 || ov !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_data[%0d]: got acc=%0d cnt=%0d out_valid=%0b ovf=%0b, want 41 4 1 0",
                         i, acc, c, ovl, ov);
            end
        end
        drive(0, 0, 4'h0, 0, 1);
        tick();
        drive(0, 0, 4'h0, 0, 0);
        sample(0, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== 0 || c !== 0 || ovl !== 1'b0 || ir !== 1'b1) begin
            n_bad++;
            $display("FAIL release: got acc=%0d cnt=%0d out_valid=%0b in_ready=%0b, want 0 0 0 1",
                     acc, c, ovl, ir);
        end
    endtask

    task automatic test_async_reset();
        int acc, c; bit ov, ir, ovl;
        int total = 0;
        drive(0, 1, 4'd5, 0, 0);
        tick();
        tick();
        drive(0, 0, 4'h0, 0, 0);
        sample(0, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== 10 || c !== 2) begin
            n_bad++;
            $display("FAIL pre_reset: got acc=%0d cnt=%0d, want 10 2", acc, c);
        end
        #2;
        rst = 1'b1;
        #1;
        sample(0, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== 0 || c !== 0 || ovl !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got acc=%0d cnt=%0d out_valid=%0b, want 0 0 0", acc, c, ovl);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int v;
            v = int'($urandom_range(0, 31));
            drive(0, 1, 4'(v), v[4], 0);
            tick();
            total += v;
            drive(0, 0, 4'h0, 0, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        sample(0, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== total || c !== 4 || ovl !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_batch: got acc=%0d cnt=%0d out_valid=%0b, want %0d 4 1", acc, c, ovl, total);
        end
        drive(0, 0, 4'h0, 0, 1);
        tick();
        drive(0, 0, 4'h0, 0, 0);
    endtask

    // Reference model: a batch is a running arithmetic total plus a "full" flag.
    task automatic run_model(input int sel, input int cycles, input bit toggle, output int batches);
        int  width = (sel == 1) ? 6 : 8;
        int  modv  = 1 << width;
        bit  m_done = 0;
        int  m_k = 0;
        int  m_total = 0;
        int  acc, c; bit ov, ir, ovl;
        batches = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            bit iv, orr, cy;
            int s;
            iv  = toggle ? (cyc % 2 == 0) : bit'($urandom_range(0, 1));
            orr = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
            s   = toggle ? 1 : int'($urandom_range(0, 15));
            cy  = toggle ? 1'b0 : bit'($urandom_range(0, 1));
            drive(sel, iv, 4'(s), cy, orr);
            sample(sel, acc, c, ov, ir, ovl);
            if (ovl) batches++;
            n_cmp++;
            if (ir !== !m_done || ovl !== m_done) begin
                n_bad++;
                $display("FAIL model_hs[%0d]: got in_ready=%0b out_valid=%0b, want %0b %0b",
                         cyc, ir, ovl, !m_done, m_done);
            end
            tick();
            if (m_done) begin
                if (orr) begin
                    m_done = 0; m_k = 0; m_total = 0;
                end
            end else if (iv) begin
                m_total = (m_k == 0) ? (cy * 16 + s) : (m_total + cy * 16 + s);
                m_k++;
                if (m_k == 4) m_done = 1;
            end
            sample(sel, acc, c, ov, ir, ovl);
            n_cmp++;
            if (acc !== m_total % modv || c !== m_k || ov !== (m_total >= modv)) begin
                n_bad++;
                $display("FAIL model_data[%0d]: got acc=%0d cnt=%0d ovf=%0b, want %0d %0d %0b",
                         cyc, acc, c, ov, m_total % modv, m_k, (m_total >= modv));
            end
        end
        drive(sel, 0, 4'h0, 0, 1);
        tick();
        drive(sel, 0, 4'h0, 0, 0);
    endtask

    task automatic test_toggle();
        int batches;
        run_model(0, 32, 1'b1, batches);
        n_cmp++;
        if (batches !== 4) begin
            n_bad++;
            $display("FAIL toggle_batches: got %0d out_valid cycles, want 4", batches);
        end
    endtask

    task automatic test_wrap6();
        int acc, c; bit ov, ir, ovl;
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 4'hF, 1, 0);
            tick();
            sample(1, acc, c, ov, ir, ovl);
            n_cmp++;
            if (acc !== (31 * k) % 64 || ov !== (31 * k >= 64) || ovl !== (k == 4)) begin
                n_bad++;
                $display("FAIL wrap6[%0d]: got acc=%0d ovf=%0b out_valid=%0b, want %0d %0b %0b",
                         k, acc, ov, ovl, (31 * k) % 64, (31 * k >= 64), (k == 4));
            end
        end
        drive(1, 0, 4'h0, 0, 1);
        tick();
        drive(1, 1, 4'd1, 0, 0);
        tick();
        sample(1, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== 1 || c !== 1 || ov !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got acc=%0d cnt=%0d ovf=%0b, want 1 1 0", acc, c, ov);
        end
        repeat (3) tick();
        drive(1, 0, 4'h0, 0, 1);
        tick();
        drive(1, 0, 4'h0, 0, 0);
    endtask

    task automatic test_wrap5();
        int acc, c; bit ov, ir, ovl;
        drive(3, 1, 4'hF, 1, 0);
        tick();
        drive(3, 1, 4'h1, 0, 0);
        tick();
        drive(3, 0, 4'h0, 0, 0);
        sample(3, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== 0 || ov !== 1'b1 || ovl !== 1'b1 || c !== 2) begin
            n_bad++;
            $display("FAIL wrap5: got acc=%0d ovf=%0b out_valid=%0b cnt=%0d, want 0 1 1 2", acc, ov, ovl, c);
        end
        drive(3, 0, 4'h0, 0, 1);
        tick();
        drive(3, 0, 4'h0, 0, 0);
    endtask

    task automatic test_count1();
        int acc, c; bit ov, ir, ovl;
        drive(2, 1, 4'h3, 1, 0);
        tick();
        drive(2, 0, 4'h0, 0, 0);
        sample(2, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== 19 || c !== 1 || ovl !== 1'b1 || ir !== 1'b0) begin
            n_bad++;
            $display("FAIL count1: got acc=%0d cnt=%0d out_valid=%0b in_ready=%0b, want 19 1 1 0",
                     acc, c, ovl, ir);
        end
        drive(2, 0, 4'h0, 0, 1);
        tick();
        drive(2, 0, 4'h0, 0, 0);
        sample(2, acc, c, ov, ir, ovl);
        n_cmp++;
        if (acc !== 0 || ovl !== 1'b0 || ir !== 1'b1) begin
            n_bad++;
            $display("FAIL count1_release: got acc=%0d out_valid=%0b in_ready=%0b, want 0 0 1", acc, ovl, ir);
        end
    endtask

    task automatic test_random();
        int batches;
        run_model(1, 400, 1'b0, batches);
    endtask

    initial begin
        test_reset();
        test_directed_batch();
        test_done_hold();
        test_async_reset();
        test_toggle();
        test_wrap6();
        test_wrap5();
        test_count1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
